cmd_proc: RTL and testbench
===========================

# cmd_proc

Command processor for the logic analyzer, sitting directly downstream of the UART command wrapper. It consumes the 16-bit host command when `cmd_rdy` is asserted, writes or reads an 8-entry configuration register file, or dumps one channel of the capture RAM. Every command returns at least one byte over the wrapper's response path (`send_resp`/`resp`/`resp_sent`).

## Interface
- `ENTRIES`, 384: capture RAM depth in samples.
- `AW`, 9: capture RAM address width; must satisfy `ENTRIES <= 2**AW`.
- `clk`  in  1  system clock, all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_rdy`  in  1  a full 16-bit command is valid on `cmd`.
- `cmd`  in  16  command word:
  - `[15:14]` opcode: 00 = read, 01 = write, 10 = dump, 11 = illegal.
  - `[13:8]` register address, or channel for dump in `[10:8]`.
  - `[7:0]` write data.
- `clr_cmd_rdy`  out  1  one-cycle pulse that acknowledges the command to the wrapper.
- `send_resp`  out  1  one-cycle pulse that starts transmission of `resp`.
- `resp`  out  8  response byte, held stable until `resp_sent`.
- `resp_sent`  in  1  UART transmit-done level.
- `cfg_regs`  out  64  flattened register file; reg n is bits `[8n+7:8n]`.
- `trig_pos`  in  AW  RAM address of the trigger sample.
- `ram_addr`  out  AW  capture RAM read address.
- `ch_sel`  out  3  channel being dumped.
- `ram_rdata`  in  8  RAM read data, one cycle after `ram_addr`.

## Operation
- **Responses:**
  - Positive ack is `0xA5`.
  - Negative ack is `0xEE`.
- **States:** IDLE, RESP_WAIT, DUMP_RD, DUMP_SEND, DUMP_WAIT.
- **IDLE with `cmd_rdy` = 1:** assert `clr_cmd_rdy` combinationally in that cycle, then decode the opcode.
  - **Write to address 0–7:** the register takes `cmd[7:0]` at the next edge. `resp` = `0xA5` and `send_resp` pulse; go to RESP_WAIT.
  - **Read from address 0–7:** `resp` = register value; `send_resp` pulse; go to RESP_WAIT.
  - **Read or write to address > 7:** no register changes. `resp` = `0xEE`; go to RESP_WAIT.
  - **Dump:**
    - Latch `ch_sel` = `cmd[10:8]`.
    - `ram_addr` = `trig_pos`+1, wrapping to 0 when `trig_pos` = `ENTRIES`-1.
    - Byte counter = 0; go to DUMP_RD.
    - A channel > 4 yields `0xEE` and RESP_WAIT instead.
  - **Opcode 11:** `0xEE`; go to RESP_WAIT.
- **RESP_WAIT:** on `resp_sent` go to IDLE.
- **DUMP_RD:** one-cycle RAM latency; go to DUMP_SEND.
- **DUMP_SEND:** `resp` = `ram_rdata` (registered), `send_resp` pulse; go to DUMP_WAIT.
- **DUMP_WAIT:** on `resp_sent`:
  - Increment the counter.
  - Advance `ram_addr`, wrapping from `ENTRIES`-1 to 0.
  - If the counter reaches `ENTRIES`, go to IDLE; otherwise go to DUMP_RD.
- **Commands while busy:** `cmd_rdy` is ignored and not cleared outside IDLE. The pending command is taken on the first IDLE cycle.
- **Register reset values:**
  - reg0 (trigger config) = `0x03`.
  - reg1–reg5 (channel trigger configs) = `0x01`.
  - reg6, reg7 = `0x00`.

## Timing
- **Reset values:**
  - `clr_cmd_rdy`, `send_resp` = 0.
  - `resp`, `ram_addr`, `ch_sel` = 0.
  - `cfg_regs` at the register reset values.
  - State = IDLE.
- **Latency:**
  - `send_resp` is asserted one cycle after `clr_cmd_rdy` for read, write and nack.
  - Each dump byte costs 2 cycles plus the UART frame time.
- **`resp_sent` guard:** `resp_sent` is ignored in the first cycle after a `send_resp` pulse, because the UART clears its done flag one cycle late.
- **`send_resp` width:** never high for more than one cycle, and never re-asserted before `resp_sent` is accepted.
- **Write-then-read:** a write followed immediately by a read of the same register returns the new value.
- **Reset mid-dump:** returns to IDLE on the next cycle with outputs at reset values. A partially sent byte is abandoned.

## Configuration
- **`CMD_PROC_DUMP_EN` defined:** dump opcode, RAM ports and the DUMP_* states are implemented as described above.
- **`CMD_PROC_DUMP_EN` undefined:**
  - Opcode 10 is treated as illegal (`0xEE`).
  - `ram_addr` and `ch_sel` are tied to 0.
  - DUMP_* states are absent.

## Test plan
- **Write:** after reset, `cmd` = `0x4312` with `cmd_rdy` → `clr_cmd_rdy` pulse, reg3 = `0x12`, `resp` = `0xA5`, one `send_resp`; IDLE after `resp_sent`.
- **Read:** `cmd` = `0x0000` → `resp` = `0x03`. Then `cmd` = `0x0300` after the write above → `resp` = `0x12`.
- **Illegal commands:**
  - `cmd` = `0x4A55` (address 10) → `resp` = `0xEE`, no register change.
  - `cmd` = `0xC000` → `0xEE`.
- **Dump with wrap** (`ENTRIES` = 8 build, `trig_pos` = 6, RAM pattern addr+`0x30`), `cmd` = `0x8200`:
  - `ch_sel` = 2.
  - Exactly 8 `send_resp` pulses with bytes `0x37,0x30,0x31,…,0x36`, then IDLE.
- **Busy:** `cmd_rdy` raised during a dump → no `clr_cmd_rdy` until the dump ends, then the command is serviced.
- **Reset mid-dump:** assert `rst_n` low after the 3rd byte → all outputs at reset values, `cfg_regs` restored, next command serviced normally.

Source files
------------

// File: rtl/cmd_proc.sv
// Logic analyzer command processor: decodes host commands, owns the 8-entry config
// register file and streams one capture channel back. Dump support needs CMD_PROC_DUMP_EN.
module cmd_proc #(
    parameter int ENTRIES = 384,
    parameter int AW      = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_rdy,
    input  logic [15:0]   cmd,
    output logic          clr_cmd_rdy,
    output logic          send_resp,
    output logic [7:0]    resp,
    input  logic          resp_sent,
    output logic [63:0]   cfg_regs,
    input  logic [AW-1:0] trig_pos,
    output logic [AW-1:0] ram_addr,
    output logic [2:0]    ch_sel,
    input  logic [7:0]    ram_rdata
);

    localparam logic [7:0] ACK  = 8'hA5;
    localparam logic [7:0] NACK = 8'hEE;
    localparam logic [7:0] CFG_RST [8] = '{8'h03, 8'h01, 8'h01, 8'h01,
                                           8'h01, 8'h01, 8'h00, 8'h00};

`ifdef CMD_PROC_DUMP_EN
    localparam int CW = $clog2(ENTRIES + 1);
    typedef enum logic [2:0] {IDLE, RESP_WAIT, DUMP_RD, DUMP_SEND, DUMP_WAIT} state_t;
`else
    typedef enum logic [0:0] {IDLE, RESP_WAIT} state_t;
`endif

    state_t      state_q, state_d;
    logic [7:0]  cfg_q [8];
    logic [7:0]  cfg_d [8];
    logic [7:0]  resp_q, resp_d;
    logic        send_resp_q, send_resp_d;
    logic        guard_q, guard_d;
    logic        take_cmd;
    logic        addr_ok;
    logic        resp_ok;

`ifdef CMD_PROC_DUMP_EN
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [2:0]    ch_sel_q, ch_sel_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == AW'(ENTRIES - 1)) ? '0 : a + 1'b1;
    endfunction
`endif

    assign addr_ok = (cmd[13:11] == 3'b000);
    // The UART drops its done flag a cycle late, so resp_sent is stale during the
    // pulse cycle and the one after it.
    assign resp_ok = resp_sent && !send_resp_q && !guard_q;

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        resp_d      = resp_q;
        send_resp_d = 1'b0;
        guard_d     = send_resp_q;
        take_cmd    = 1'b0;
`ifdef CMD_PROC_DUMP_EN
        ram_addr_d  = ram_addr_q;
        ch_sel_d    = ch_sel_q;
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_rdy) begin
                    take_cmd    = 1'b1;
                    send_resp_d = 1'b1;
                    resp_d      = NACK;
                    state_d     = RESP_WAIT;
                    case (cmd[15:14])
                        2'b00: if (addr_ok) resp_d = cfg_q[cmd[10:8]];
                        2'b01: begin
                            if (addr_ok) begin
                                cfg_d[cmd[10:8]] = cmd[7:0];
                                resp_d           = ACK;
                            end
                        end
`ifdef CMD_PROC_DUMP_EN
                        2'b10: begin
                            if (cmd[10:8] <= 3'd4) begin
                                send_resp_d = 1'b0;
                                resp_d      = resp_q;
                                ch_sel_d    = cmd[10:8];
                                ram_addr_d  = next_addr(trig_pos);
                                cnt_d       = '0;
                                state_d     = DUMP_RD;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RESP_WAIT: begin
                if (resp_ok) state_d = IDLE;
            end
`ifdef CMD_PROC_DUMP_EN
            DUMP_RD: state_d = DUMP_SEND;
            DUMP_SEND: begin
                resp_d      = ram_rdata;
                send_resp_d = 1'b1;
                state_d     = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                if (resp_ok) begin
                    cnt_d      = cnt_q + 1'b1;
                    ram_addr_d = next_addr(ram_addr_q);
                    state_d    = (cnt_q == CW'(ENTRIES - 1)) ? IDLE : DUMP_RD;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            resp_q      <= '0;
            send_resp_q <= 1'b0;
            guard_q     <= 1'b0;
            for (int i = 0; i < 8; i++) cfg_q[i] <= CFG_RST[i];
`ifdef CMD_PROC_DUMP_EN
            ram_addr_q  <= '0;
            ch_sel_q    <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            resp_q      <= resp_d;
            send_resp_q <= send_resp_d;
            guard_q     <= guard_d;
            for (int i = 0; i < 8; i++) cfg_q[i] <= cfg_d[i];
`ifdef CMD_PROC_DUMP_EN
            ram_addr_q  <= ram_addr_d;
            ch_sel_q    <= ch_sel_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cfg_flat
            assign cfg_regs[8*gi +: 8] = cfg_q[gi];
        end
    endgenerate

    // Acknowledge is combinational from state, so keep it quiet while reset is held.
    assign clr_cmd_rdy = take_cmd & rst_n;
    assign send_resp   = send_resp_q;
    assign resp        = resp_q;

`ifdef CMD_PROC_DUMP_EN
    assign ram_addr    = ram_addr_q;
    assign ch_sel      = ch_sel_q;
`else
    logic unused_dump_inputs;
    assign unused_dump_inputs = ^{trig_pos, ram_rdata};
    assign ram_addr    = '0;
    assign ch_sel      = '0;
`endif

endmodule

// File: tb/tb_cmd_proc.sv
// Directed self-checking bench for cmd_proc (ENTRIES=8, AW=4); dump tests run only
// when CMD_PROC_DUMP_EN is defined, otherwise opcode 10 is checked as a nack.
module tb_cmd_proc;

    localparam int ENTRIES = 8;
    localparam int AW      = 4;
    localparam logic [63:0] CFG_RST = 64'h0000_0101_0101_0103;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_rdy;
    logic [15:0]   cmd;
    logic          clr_cmd_rdy;
    logic          send_resp;
    logic [7:0]    resp;
    logic          resp_sent;
    logic [63:0]   cfg_regs;
    logic [AW-1:0] trig_pos;
    logic [AW-1:0] ram_addr;
    logic [2:0]    ch_sel;
    logic [7:0]    ram_rdata = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    cmd_proc #(.ENTRIES(ENTRIES), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_rdy    (cmd_rdy),
        .cmd        (cmd),
        .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp  (send_resp),
        .resp       (resp),
        .resp_sent  (resp_sent),
        .cfg_regs   (cfg_regs),
        .trig_pos   (trig_pos),
        .ram_addr   (ram_addr),
        .ch_sel     (ch_sel),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // Capture RAM: content is address + 0x30, one cycle read latency.
    always @(posedge clk) ram_rdata <= 8'h30 + 8'(ram_addr);

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_clr"},  clr_cmd_rdy, 1'b0);
        check_eq({tag, "_send"}, send_resp, 1'b0);
        check_eq({tag, "_resp"}, resp, 8'h00);
        check_eq({tag, "_addr"}, ram_addr, '0);
        check_eq({tag, "_ch"},   ch_sel, 3'd0);
        check_eq({tag, "_cfg"},  cfg_regs, CFG_RST);
    endtask

    // Called on the negedge where send_resp was seen: checks it is a single
    // pulse, then returns a UART done pulse clear of the stale-flag window.
    task automatic finish_resp(input string tag);
        @(negedge clk);
        check_eq({tag, "_1pulse"}, send_resp, 1'b0);
        @(negedge clk);
        resp_sent = 1'b1;
        @(negedge clk);
        resp_sent = 1'b0;
    endtask

    task automatic do_cmd(input logic [15:0] c, input logic [7:0] exp_resp, input string tag);
        @(negedge clk);
        cmd = c;
        cmd_rdy = 1'b1;
        #1;
        check_eq({tag, "_clr"}, clr_cmd_rdy, 1'b1);
        @(negedge clk);
        cmd_rdy = 1'b0;
        check_eq({tag, "_send"}, send_resp, 1'b1);
        check_eq({tag, "_resp"}, resp, exp_resp);
        finish_resp(tag);
        $display("cmd %04h -> resp %02h (expected %02h)", c, resp, exp_resp);
    endtask

    task automatic wait_send(output logic got, output logic clr_seen);
        got = 1'b0;
        clr_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (clr_cmd_rdy) clr_seen = 1'b1;
            if (send_resp) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic got;
        logic clr_seen;
        logic busy_clr;
        rst_n = 1'b0;
        cmd_rdy = 1'b0;
        cmd = 16'h0000;
        resp_sent = 1'b0;
        trig_pos = AW'(6);
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;

        do_cmd(16'h4312, 8'hA5, "wr3");
        check_eq("wr3_cfg", cfg_regs, 64'h0000_0101_1201_0103);
        do_cmd(16'h0000, 8'h03, "rd0");
        do_cmd(16'h0300, 8'h12, "rd3");
        do_cmd(16'h4A55, 8'hEE, "wr10");
        check_eq("wr10_cfg", cfg_regs, 64'h0000_0101_1201_0103);
        do_cmd(16'h0A00, 8'hEE, "rd10");
        do_cmd(16'hC000, 8'hEE, "op11");
        do_cmd(16'h4777, 8'hA5, "wr7");
        do_cmd(16'h0700, 8'h77, "rd7");

        // Stale resp_sent during the pulse and guard cycles must not end the response.
        @(negedge clk);
        cmd = 16'h4155;
        cmd_rdy = 1'b1;
        #1;
        check_eq("grd_clr", clr_cmd_rdy, 1'b1);
        @(negedge clk);
        cmd = 16'h0100;
        resp_sent = 1'b1;
        check_eq("grd_send", send_resp, 1'b1);
        check_eq("grd_resp", resp, 8'hA5);
        #1;
        check_eq("grd_busy0", clr_cmd_rdy, 1'b0);
        @(negedge clk);
        #1;
        check_eq("grd_busy1", clr_cmd_rdy, 1'b0);
        @(negedge clk);
        resp_sent = 1'b0;
        #1;
        check_eq("grd_busy2", clr_cmd_rdy, 1'b0);
        @(negedge clk);
        resp_sent = 1'b1;
        @(negedge clk);
        resp_sent = 1'b0;
        #1;
        check_eq("grd_take", clr_cmd_rdy, 1'b1);
        @(negedge clk);
        cmd_rdy = 1'b0;
        check_eq("grd_rd_send", send_resp, 1'b1);
        check_eq("grd_rd_resp", resp, 8'h55);
        finish_resp("grd_rd");
        $display("guard: pending read of reg1 -> resp %02h (expected 55)", resp);

`ifdef CMD_PROC_DUMP_EN
        // Dump channel 2 from trig_pos=6 with a read command pending throughout.
        @(negedge clk);
        cmd = 16'h8200;
        cmd_rdy = 1'b1;
        #1;
        check_eq("dmp_clr", clr_cmd_rdy, 1'b1);
        @(negedge clk);
        cmd = 16'h0300;
        #1;
        check_eq("dmp_ch", ch_sel, 3'd2);
        check_eq("dmp_addr0", ram_addr, AW'(7));
        check_eq("dmp_busy_first", clr_cmd_rdy, 1'b0);
        busy_clr = 1'b0;
        for (int b = 0; b < ENTRIES; b++) begin
            wait_send(got, clr_seen);
            busy_clr |= clr_seen;
            check_eq("dmp_pulse", got, 1'b1);
            check_eq("dmp_byte", resp, 8'h30 + 8'((7 + b) % ENTRIES));
            $display("dump byte %0d: %02h (expected %02h)", b, resp, 8'h30 + 8'((7 + b) % ENTRIES));
            @(negedge clk);
            #1;
            busy_clr |= clr_cmd_rdy;
            check_eq("dmp_1pulse", send_resp, 1'b0);
            @(negedge clk);
            resp_sent = 1'b1;
            #1;
            busy_clr |= clr_cmd_rdy;
            @(negedge clk);
            resp_sent = 1'b0;
        end
        check_eq("dmp_busy", busy_clr, 1'b0);
        #1;
        check_eq("dmp_end_take", clr_cmd_rdy, 1'b1);
        @(negedge clk);
        cmd_rdy = 1'b0;
        check_eq("dmp_rd_send", send_resp, 1'b1);
        check_eq("dmp_rd_resp", resp, 8'h12);
        finish_resp("dmp_rd");

        do_cmd(16'h8500, 8'hEE, "dmp_ch5");

        // Reset after the third dump byte has been launched.
        @(negedge clk);
        cmd = 16'h8200;
        cmd_rdy = 1'b1;
        @(negedge clk);
        cmd_rdy = 1'b0;
        for (int b = 0; b < 3; b++) begin
            wait_send(got, clr_seen);
            check_eq("mid_pulse", got, 1'b1);
            if (b < 2) begin
                @(negedge clk);
                @(negedge clk);
                resp_sent = 1'b1;
                @(negedge clk);
                resp_sent = 1'b0;
            end
        end
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        $display("reset mid-dump: cfg_regs %016h (expected %016h)", cfg_regs, CFG_RST);
        @(negedge clk);
        rst_n = 1'b1;
`else
        do_cmd(16'h8200, 8'hEE, "dmp_off");
        check_eq("dmp_off_addr", ram_addr, '0);
        check_eq("dmp_off_ch", ch_sel, 3'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        $display("reset: cfg_regs %016h (expected %016h)", cfg_regs, CFG_RST);
        @(negedge clk);
        rst_n = 1'b1;
`endif
        do_cmd(16'h0300, 8'h01, "post_rd3");
        do_cmd(16'h0000, 8'h03, "post_rd0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
